// File: rtl/fmap_readback.sv
// ---------------------------------------------------------------------------
// fmap_readback
// Reads one PIX_W x PIX_H feature map (row-major bytes at BASE_ADDR) out of
// the shared display BRAM and streams it column by column over a valid/ready
// handshake. For each column, every row is read with one BRAM read per cycle.
// The results are gathered in a column buffer. The full column is presented
// once the last row has landed.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   start           1-cycle request to read one full map (honoured in IDLE only)
//   busy            high from start acceptance until the done cycle
//   bram_en/addr    registered BRAM read request, one address per cycle
//   bram_rdata      BRAM data, valid RD_LAT cycles after the request
//   valid_col       column available on data_col
//   ready_col       consumer accepts the column
//   data_col        row r in [r*24 +: 24], pixel MSB-aligned, low bits zero
//   done            1-cycle pulse after the last column is accepted
// ---------------------------------------------------------------------------
module fmap_readback #(
  parameter int PIX_W     = 24,
  parameter int PIX_H     = 24,
  parameter int BASE_ADDR = 0,
  parameter int PIX_BITS  = 8,
  parameter int RD_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  bram_en,
  output logic [15:0]           bram_addr,
  input  logic [PIX_BITS-1:0]   bram_rdata,
  output logic                  valid_col,
  input  logic                  ready_col,
  output logic [PIX_H*24-1:0]   data_col,
  output logic                  done
);

  localparam int CW = $clog2((PIX_W > 2) ? PIX_W : 2);
  localparam int RW = $clog2((PIX_H > 2) ? PIX_H : 2);
  localparam logic [CW-1:0] LAST_COL = CW'(PIX_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(PIX_H - 1);

  // Parameter legality, checked at elaboration.
  if (BASE_ADDR + PIX_W * PIX_H > 65536) begin : g_bad_map
    $error("fmap_readback: BASE_ADDR + PIX_W*PIX_H exceeds 16-bit address space");
  end
  if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_lat
    $error("fmap_readback: RD_LAT must be 1..3");
  end
  if (PIX_BITS < 1 || PIX_BITS > 24) begin : g_bad_bits
    $error("fmap_readback: PIX_BITS must be 1..24");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, PRESENT = 2'd2} state_t;

  state_t                         state_q, state_d;
  logic                           busy_q, busy_d;
  logic                           en_q, en_d;
  logic                           valid_q, valid_d;
  logic                           done_q, done_d;
  logic [15:0]                    addr_q, addr_d;
  logic [CW-1:0]                  col_q, col_d;
  logic [RW-1:0]                  row_q, row_d;     // row of the address on bram_addr
  logic [RD_LAT-1:0]              pv_q, pv_d;       // read-in-flight valid pipeline
  logic [RD_LAT-1:0][RW-1:0]      prow_q, prow_d;   // row index travelling with each read
  logic [PIX_H-1:0][PIX_BITS-1:0] buf_q, buf_d;     // column buffer

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    en_d    = en_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    addr_d  = addr_q;
    col_d   = col_q;
    row_d   = row_q;
    buf_d   = buf_q;

    // The pipeline tracks each issued read so its data lands in the right row.
    pv_d[0]   = en_q;
    prow_d[0] = row_q;
    for (int k = 1; k < RD_LAT; k++) begin
      pv_d[k]   = pv_q[k-1];
      prow_d[k] = prow_q[k-1];
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          busy_d  = 1'b1;
          col_d   = '0;
          row_d   = '0;
          en_d    = 1'b1;
          addr_d  = 16'(BASE_ADDR);
        end
      end

      READ: begin
        if (en_q) begin
          if (row_q == LAST_ROW) begin
            en_d = 1'b0;
          end else begin
            row_d  = row_q + RW'(1);
            addr_d = addr_q + 16'(PIX_W);
          end
        end
        if (pv_q[RD_LAT-1]) begin
          buf_d[prow_q[RD_LAT-1]] = bram_rdata;
          if (prow_q[RD_LAT-1] == LAST_ROW) begin
            state_d = PRESENT;
            valid_d = 1'b1;
          end
        end
      end

      PRESENT: begin
        // valid_col is always high here, so ready_col alone completes the handshake.
        if (ready_col) begin
          valid_d = 1'b0;
          if (col_q == LAST_COL) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = READ;
            col_d   = col_q + CW'(1);
            row_d   = '0;
            en_d    = 1'b1;
            addr_d  = 16'(BASE_ADDR + int'(col_q) + 1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      pv_q    <= '0;
      prow_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      col_q   <= col_d;
      row_q   <= row_d;
      pv_q    <= pv_d;
      prow_q  <= prow_d;
      buf_q   <= buf_d;
    end
  end

  assign busy      = busy_q;
  assign bram_en   = en_q;
  assign bram_addr = addr_q;
  assign valid_col = valid_q;
  assign done      = done_q;

  for (genvar gi = 0; gi < PIX_H; gi++) begin : g_col
    assign data_col[gi*24 +: 24] = 24'(buf_q[gi]) << (24 - PIX_BITS);
  end

endmodule

// File: tb/tb_fmap_readback.sv
// ---------------------------------------------------------------------------
// tb_fmap_readback
// Three fmap_readback instances with different geometries:
//   0: 4x3,   RD_LAT=1, BASE 0x000, mem[a] = a
//   1: 2x2,   RD_LAT=3, BASE 0x100, random contents
//   2: 24x24, RD_LAT=1, BASE 0x000, random contents, random ready
// A per-instance scoreboard derives expected addresses and column data from
// the address map (BASE + row*W + col) and checks every read, handshake and
// done. A table of timing checkpoints pins the exact cycle behaviour.
// ---------------------------------------------------------------------------
module tb_fmap_readback;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam int PW [3] = '{4, 2, 24};
  localparam int PH [3] = '{3, 2, 24};
  localparam int PB [3] = '{0, 256, 0};

  logic rst_r [3];
  logic start_r [3];
  logic ready_r [3];

  logic        busy_a, en_a, valid_a, done_a;
  logic        busy_b, en_b, valid_b, done_b;
  logic        busy_c, en_c, valid_c, done_c;
  logic [15:0] addr_a, addr_b, addr_c;
  logic [7:0]  rdata_a, rdata_b, rdata_c;
  logic [71:0]  data_a;
  logic [47:0]  data_b;
  logic [575:0] data_c;

  fmap_readback #(.PIX_W(4), .PIX_H(3), .BASE_ADDR(0), .PIX_BITS(8), .RD_LAT(1)) u_a (
    .clk(clk), .rst(rst_r[0]), .start(start_r[0]), .busy(busy_a), .bram_en(en_a),
    .bram_addr(addr_a), .bram_rdata(rdata_a), .valid_col(valid_a), .ready_col(ready_r[0]),
    .data_col(data_a), .done(done_a));

  fmap_readback #(.PIX_W(2), .PIX_H(2), .BASE_ADDR(256), .PIX_BITS(8), .RD_LAT(3)) u_b (
    .clk(clk), .rst(rst_r[1]), .start(start_r[1]), .busy(busy_b), .bram_en(en_b),
    .bram_addr(addr_b), .bram_rdata(rdata_b), .valid_col(valid_b), .ready_col(ready_r[1]),
    .data_col(data_b), .done(done_b));

  fmap_readback #(.PIX_W(24), .PIX_H(24), .BASE_ADDR(0), .PIX_BITS(8), .RD_LAT(1)) u_c (
    .clk(clk), .rst(rst_r[2]), .start(start_r[2]), .busy(busy_c), .bram_en(en_c),
    .bram_addr(addr_c), .bram_rdata(rdata_c), .valid_col(valid_c), .ready_col(ready_r[2]),
    .data_col(data_c), .done(done_c));

  // BRAM models: data for a request appears RD_LAT cycles later; junk otherwise.
  logic [7:0] mem [3][65536];
  logic [7:0] pa, pc;
  logic [7:0] pb [3];
  always @(posedge clk) begin
    pa    <= en_a ? mem[0][addr_a] : 8'($urandom);
    pb[0] <= en_b ? mem[1][addr_b] : 8'($urandom);
    pb[1] <= pb[0];
    pb[2] <= pb[1];
    pc    <= en_c ? mem[2][addr_c] : 8'($urandom);
  end
  assign rdata_a = pa;
  assign rdata_b = pb[2];
  assign rdata_c = pc;

  // Uniform views of the three instances.
  logic         en_w [3], valid_w [3], done_w [3], busy_w [3];
  logic [15:0]  addr_w [3];
  logic [575:0] dat_w [3];
  always_comb begin
    en_w[0] = en_a;     en_w[1] = en_b;     en_w[2] = en_c;
    valid_w[0] = valid_a; valid_w[1] = valid_b; valid_w[2] = valid_c;
    done_w[0] = done_a; done_w[1] = done_b; done_w[2] = done_c;
    busy_w[0] = busy_a; busy_w[1] = busy_b; busy_w[2] = busy_c;
    addr_w[0] = addr_a; addr_w[1] = addr_b; addr_w[2] = addr_c;
    dat_w[0] = 576'(data_a); dat_w[1] = 576'(data_b); dat_w[2] = data_c;
  end

  int total = 0;
  int bad   = 0;

  // Scoreboard state per instance.
  bit           armed [3];
  int           n_iss [3];
  int           n_col [3];
  int           n_done [3];
  bit           stall_prev [3];
  logic [575:0] stall_dat [3];

  task automatic check(input string nm, input int id, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, id, got, exp);
    end
  endtask

  task automatic check_dat(input string nm, input int id, input logic [575:0] got,
                           input logic [575:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, id, got, exp);
    end
  endtask

  function automatic logic [575:0] exp_col(input int id, input int c);
    logic [575:0] v;
    v = '0;
    for (int r = 0; r < PH[id]; r++)
      v[r*24 +: 24] = {mem[id][16'(PB[id] + r * PW[id] + c)], 16'h0000};
    return v;
  endfunction

  task automatic begin_map(input int id);
    armed[id] = 1'b1; n_iss[id] = 0; n_col[id] = 0; n_done[id] = 0; stall_prev[id] = 1'b0;
  endtask

  task automatic monitor(input int id);
    if (stall_prev[id]) begin
      check("hold_valid", id, int'(valid_w[id]), 1);
      check_dat("hold_data", id, dat_w[id], stall_dat[id]);
    end
    stall_prev[id] = valid_w[id] && !ready_r[id];
    stall_dat[id]  = dat_w[id];
    if (en_w[id]) begin
      check("read_in_present", id, int'(valid_w[id]), 0);
      check("busy_on_read", id, int'(busy_w[id]), 1);
      if (armed[id] && n_iss[id] < PW[id] * PH[id]) begin
        check("addr", id, int'(addr_w[id]),
              PB[id] + (n_iss[id] % PH[id]) * PW[id] + n_iss[id] / PH[id]);
        n_iss[id]++;
      end else begin
        check("unexpected_read", id, int'(en_w[id]), 0);
      end
    end
    if (valid_w[id] && ready_r[id]) begin
      if (armed[id] && n_col[id] < PW[id]) begin
        check_dat("col_data", id, dat_w[id], exp_col(id, n_col[id]));
        n_col[id]++;
      end else begin
        check("unexpected_col", id, int'(valid_w[id]), 0);
      end
    end
    if (done_w[id]) begin
      n_done[id]++;
      check("done_after_last", id, n_col[id], PW[id]);
      check("busy_at_done", id, int'(busy_w[id]), 0);
      check("valid_at_done", id, int'(valid_w[id]), 0);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    for (int id = 0; id < 3; id++) monitor(id);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample();
    adv();
  endtask

  task automatic pulse_start(input int id, input bit model);
    start_r[id] = 1'b1;
    sample();
    if (model) begin_map(id);
    adv();
    start_r[id] = 1'b0;
  endtask

  // mode 0: ready high, 1: random ready, 2: hold ready low 6 cycles per column.
  task automatic run_to_done(input int id, input int max_cyc, input int mode);
    int stall;
    stall = 0;
    for (int k = 0; k < max_cyc && n_done[id] == 0; k++) begin
      if (mode == 0) ready_r[id] = 1'b1;
      else if (mode == 1) ready_r[id] = 1'($urandom_range(0, 1));
      else if (valid_w[id]) begin
        if (stall < 6) begin ready_r[id] = 1'b0; stall++; end
        else begin ready_r[id] = 1'b1; stall = 0; end
      end else begin
        ready_r[id] = 1'b0; stall = 0;
      end
      sample();
      if (n_done[id] == 0) check("busy_hold", id, int'(busy_w[id]), 1);
      adv();
    end
    ready_r[id] = 1'b0;
    repeat (4) step();
    check("done_count", id, n_done[id], 1);
    check("cols_accepted", id, n_col[id], PW[id]);
  endtask

  // Timing checkpoints relative to the start cycle (off 0), ready held high.
  typedef struct {
    int id; int off; int en; int addr; int valid; int done; int busy;
  } vec_t;
  vec_t vecs [21];

  task automatic run_table(input int id);
    start_r[id] = 1'b1;
    for (int off = 0; off < 24; off++) begin
      sample();
      for (int i = 0; i < 21; i++) begin
        if (vecs[i].id == id && vecs[i].off == off) begin
          check("t_en", id, int'(en_w[id]), vecs[i].en);
          check("t_valid", id, int'(valid_w[id]), vecs[i].valid);
          check("t_done", id, int'(done_w[id]), vecs[i].done);
          check("t_busy", id, int'(busy_w[id]), vecs[i].busy);
          if (vecs[i].en != 0) check("t_addr", id, int'(addr_w[id]), vecs[i].addr);
        end
      end
      if (off == 0) begin_map(id);
      adv();
      start_r[id] = 1'b0;
    end
    check("done_count", id, n_done[id], 1);
    check("cols_accepted", id, n_col[id], PW[id]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog[0]: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs = '{
      '{0,  0, 0, 0,     0, 0, 0}, '{0,  1, 1, 0,     0, 0, 1},
      '{0,  2, 1, 4,     0, 0, 1}, '{0,  3, 1, 8,     0, 0, 1},
      '{0,  4, 0, 0,     0, 0, 1}, '{0,  5, 0, 0,     1, 0, 1},
      '{0,  6, 1, 1,     0, 0, 1}, '{0, 16, 1, 3,     0, 0, 1},
      '{0, 18, 1, 11,    0, 0, 1}, '{0, 20, 0, 0,     1, 0, 1},
      '{0, 21, 0, 0,     0, 1, 0}, '{0, 22, 0, 0,     0, 0, 0},
      '{1,  1, 1, 'h100, 0, 0, 1}, '{1,  2, 1, 'h102, 0, 0, 1},
      '{1,  3, 0, 0,     0, 0, 1}, '{1,  5, 0, 0,     0, 0, 1},
      '{1,  6, 0, 0,     1, 0, 1}, '{1,  7, 1, 'h101, 0, 0, 1},
      '{1,  8, 1, 'h103, 0, 0, 1}, '{1, 12, 0, 0,     1, 0, 1},
      '{1, 13, 0, 0,     0, 1, 0}
    };
    for (int a = 0; a < 65536; a++) begin
      mem[0][a] = 8'(a);
      mem[1][a] = 8'($urandom);
      mem[2][a] = 8'($urandom);
    end
    for (int id = 0; id < 3; id++) begin
      rst_r[id] = 1'b1; start_r[id] = 1'b0; ready_r[id] = 1'b0;
      armed[id] = 1'b0; n_iss[id] = 0; n_col[id] = 0; n_done[id] = 0;
      stall_prev[id] = 1'b0; stall_dat[id] = '0;
    end

    // Reset state.
    repeat (3) adv();
    sample();
    for (int id = 0; id < 3; id++) begin
      check("rst_en", id, int'(en_w[id]), 0);
      check("rst_addr", id, int'(addr_w[id]), 0);
      check("rst_valid", id, int'(valid_w[id]), 0);
      check("rst_busy", id, int'(busy_w[id]), 0);
      check("rst_done", id, int'(done_w[id]), 0);
      check_dat("rst_data", id, dat_w[id], '0);
    end
    adv();
    for (int id = 0; id < 3; id++) rst_r[id] = 1'b0;
    repeat (3) step();

    // Exact timing, 4x3 latency 1, ready tied high.
    ready_r[0] = 1'b1;
    run_table(0);

    // Exact timing, 2x2 latency 3, offset base.
    ready_r[1] = 1'b1;
    run_table(1);
    ready_r[1] = 1'b0;

    // Back-pressure: six stalled cycles per column.
    pulse_start(0, 1'b1);
    run_to_done(0, 300, 2);

    // Start while busy is ignored; start coincident with done is accepted.
    ready_r[0] = 1'b1;
    for (int off = 0; off <= 21; off++) begin
      start_r[0] = (off == 0 || off == 3 || off == 21);
      sample();
      if (off == 21) check("done_with_start", 0, int'(done_w[0]), 1);
      if (off == 0 || off == 21) begin_map(0);
      adv();
    end
    start_r[0] = 1'b0;
    sample();
    check("restart_issue", 0, int'(en_w[0]), 1);
    check("restart_addr", 0, int'(addr_w[0]), 0);
    adv();
    run_to_done(0, 100, 0);

    // Reset in the middle of column 2's reads aborts the map.
    ready_r[0] = 1'b1;
    pulse_start(0, 1'b1);
    repeat (11) step();
    rst_r[0] = 1'b1;
    armed[0] = 1'b0;
    stall_prev[0] = 1'b0;
    sample();
    check("abort_en", 0, int'(en_w[0]), 0);
    check("abort_addr", 0, int'(addr_w[0]), 0);
    check("abort_valid", 0, int'(valid_w[0]), 0);
    check("abort_busy", 0, int'(busy_w[0]), 0);
    check("abort_done", 0, int'(done_w[0]), 0);
    check_dat("abort_data", 0, dat_w[0], '0);
    adv();
    repeat (2) step();
    rst_r[0] = 1'b0;
    repeat (4) step();
    check("abort_no_done", 0, n_done[0], 0);
    pulse_start(0, 1'b1);
    run_to_done(0, 200, 0);

    // Full-size map, random contents, random back-pressure.
    pulse_start(2, 1'b1);
    run_to_done(2, 4000, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
